// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus bundle: video fetch, CPU req/ack and VRAM macro pins.
// slave = arbiter side, master = environment (video pipeline, CPU, VRAM model).
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  video_en;
  logic [ADDR_WIDTH-1:0] video_addr;
  logic [DATA_WIDTH-1:0] video_data;
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [1:0]            cpu_wmask;
  logic                  cpu_ack;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [1:0]            ram_wmask;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  video_en, video_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask, ram_rdata,
    output video_data, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wmask, ram_wdata
  );

  modport master (
    output video_en, video_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask, ram_rdata,
    input  video_data, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wmask, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed video read slot every 4th cycle, CPU gets the rest.
// Optional byte-mask writes enabled by defining VRAM_ARBITER_WMASK_EN.
module vram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  vram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            slot_q, slot_d;
  logic                  vid_pend_q, vid_pend_d;
  logic [DATA_WIDTH-1:0] video_data_q, video_data_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                  video_slot;
  logic                  issue;

  assign video_slot   = bus.video_en && (slot_q == 2'd3);
  assign slot_d       = bus.video_en ? slot_q + 2'd1 : 2'd0;
  assign vid_pend_d   = video_slot;
  // Capture completes even if video_en drops right after the slot.
  assign video_data_d = vid_pend_q ? bus.ram_rdata : video_data_q;
  assign cpu_rdata_d  = (state_q == S_RD) ? bus.ram_rdata : cpu_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      slot_q       <= 2'd0;
      vid_pend_q   <= 1'b0;
      video_data_q <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      vid_pend_q   <= vid_pend_d;
      video_data_q <= video_data_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  // A request that collides with the video slot simply waits in IDLE.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req && !video_slot) begin
          issue   = 1'b1;
          state_d = bus.cpu_we ? S_DONE : S_RD;
        end
      end
      S_RD:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ram_addr   = issue ? bus.cpu_addr : bus.video_addr;
  assign bus.ram_we     = issue && bus.cpu_we;
  assign bus.ram_wdata  = bus.cpu_wdata;

`ifdef VRAM_ARBITER_WMASK_EN
  assign bus.ram_wmask  = (issue && bus.cpu_we) ? bus.cpu_wmask : 2'b00;
`else
  logic unused_wmask;
  assign unused_wmask   = ^bus.cpu_wmask;
  assign bus.ram_wmask  = 2'b11;
`endif

  assign bus.cpu_ack    = (state_q == S_DONE);
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.video_data = video_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed scenarios plus randomized traffic checked
// against a shadow memory and an enabled-cycle-count model of the video slot.
module tb_vram_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // VRAM macro model: synchronous read, byte-masked write
  logic [15:0] mem [256];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bus.ram_we) begin
      if (bus.ram_wmask[1]) mem[bus.ram_addr][15:8] <= bus.ram_wdata[15:8];
      if (bus.ram_wmask[0]) mem[bus.ram_addr][7:0]  <= bus.ram_wdata[7:0];
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  logic [15:0] shadow [256];
  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] m);
`ifdef VRAM_ARBITER_WMASK_EN
    merge = {m[1] ? nw[15:8] : old[15:8], m[0] ? nw[7:0] : old[7:0]};
`else
    merge = nw;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_wmask = 2'b11;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    drive_idle();
    bus.video_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Transaction driver only: returns read data and cycles from issue to ack.
  task automatic cpu_txn(input logic we, input logic [7:0] a, input logic [15:0] d,
                         input logic [1:0] m, output logic [15:0] rd, output int lat);
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a;
    bus.cpu_wdata = d;  bus.cpu_wmask = m;
    lat = 0;
    @(negedge clk);
    while (!bus.cpu_ack && lat < 8) begin
      tick();
      @(negedge clk);
      lat++;
    end
    rd = bus.cpu_rdata;
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1;
    drive_idle();
    bus.video_en = 1'b0; bus.video_addr = 8'h5A;
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    @(negedge clk);
    tests++; if (bus.cpu_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", bus.cpu_ack); end
    tests++; if (bus.cpu_rdata !== 16'h0) begin fails++; $display("FAIL reset_rdata got %h want 0000", bus.cpu_rdata); end
    tests++; if (bus.video_data !== 16'h0) begin fails++; $display("FAIL reset_vdata got %h want 0000", bus.video_data); end
    tests++; if (bus.ram_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", bus.ram_we); end
    tests++; if (bus.ram_addr !== 8'h5A) begin fails++; $display("FAIL reset_addr got %h want 5a", bus.ram_addr); end
    tick();
    tick();
    mem_init = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    bus.video_en = 1'b0;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h12;
    bus.cpu_wdata = 16'hBEEF; bus.cpu_wmask = 2'b11;
    @(negedge clk);
    tests++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h12) begin fails++; $display("FAIL wr_issue we=%b addr=%h want 1/12", bus.ram_we, bus.ram_addr); end
    tests++; if (bus.cpu_ack !== 1'b0) begin fails++; $display("FAIL wr_early_ack got %b want 0", bus.cpu_ack); end
    tick();
    @(negedge clk);
    tests++; if (bus.ram_we !== 1'b0) begin fails++; $display("FAIL wr_we_len got %b want 0", bus.ram_we); end
    tests++; if (bus.cpu_ack !== 1'b1) begin fails++; $display("FAIL wr_ack got %b want 1", bus.cpu_ack); end
    bus.cpu_req = 1'b0;
    shadow[8'h12] = 16'hBEEF;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h12;
    @(negedge clk);
    tests++; if (bus.ram_we !== 1'b0 || bus.ram_addr !== 8'h12) begin fails++; $display("FAIL rd_issue we=%b addr=%h want 0/12", bus.ram_we, bus.ram_addr); end
    tick();
    @(negedge clk);
    tests++; if (bus.cpu_ack !== 1'b0) begin fails++; $display("FAIL rd_early_ack got %b want 0", bus.cpu_ack); end
    tick();
    @(negedge clk);
    tests++; if (bus.cpu_ack !== 1'b1) begin fails++; $display("FAIL rd_ack got %b want 1", bus.cpu_ack); end
    tests++; if (bus.cpu_rdata !== 16'hBEEF) begin fails++; $display("FAIL rd_data got %h want beef", bus.cpu_rdata); end
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_video();
    logic [15:0] rd;
    int lat;
    cpu_txn(1'b1, 8'h20, 16'h8005, 2'b11, rd, lat);
    shadow[8'h20] = 16'h8005;
    tests++; if (lat !== 1) begin fails++; $display("FAIL vid_preload_lat got %0d want 1", lat); end
    tick();
    bus.video_en = 1'b1; bus.video_addr = 8'h20;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      if (k % 4 == 3) begin
        tests++; if (bus.ram_addr !== 8'h20 || bus.ram_we !== 1'b0) begin fails++; $display("FAIL vid_slot k=%0d addr=%h we=%b want 20/0", k, bus.ram_addr, bus.ram_we); end
      end
      tests++;
      if (bus.video_data !== ((k >= 5) ? 16'h8005 : 16'h0000)) begin
        fails++; $display("FAIL vid_data k=%0d got %h want %h", k, bus.video_data, (k >= 5) ? 16'h8005 : 16'h0000);
      end
    end
    tick();
    bus.video_en = 1'b0;
  endtask

  task automatic test_collision();
    logic [15:0] rd;
    int lat;
    cpu_txn(1'b1, 8'h05, 16'h5A5A, 2'b11, rd, lat);
    shadow[8'h05] = 16'h5A5A;
    tick();
    bus.video_en = 1'b1; bus.video_addr = 8'h20;
    for (int k = 0; k < 11; k++) begin
      if (k > 0) tick();
      if (k == 3) begin bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h05; end
      @(negedge clk);
      if (k == 3) begin
        tests++; if (bus.ram_addr !== 8'h20 || bus.ram_we !== 1'b0) begin fails++; $display("FAIL col_slot addr=%h we=%b want 20/0", bus.ram_addr, bus.ram_we); end
      end
      if (k == 4) begin
        tests++; if (bus.ram_addr !== 8'h05) begin fails++; $display("FAIL col_issue addr=%h want 05", bus.ram_addr); end
      end
      if (k >= 3 && k <= 5) begin
        tests++; if (bus.cpu_ack !== 1'b0) begin fails++; $display("FAIL col_early_ack k=%0d got %b want 0", k, bus.cpu_ack); end
      end
      if (k == 6) begin
        tests++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 16'h5A5A) begin fails++; $display("FAIL col_ack ack=%b data=%h want 1/5a5a", bus.cpu_ack, bus.cpu_rdata); end
        bus.cpu_req = 1'b0;
      end
      if (k >= 6) begin
        tests++; if (bus.video_data !== 16'h8005) begin fails++; $display("FAIL col_vdata k=%0d got %h want 8005", k, bus.video_data); end
      end
    end
    tick();
    bus.video_en = 1'b0;
  endtask

  task automatic test_wmask();
    logic [15:0] rd, want;
    int lat;
    bus.video_en = 1'b0;
    cpu_txn(1'b1, 8'h30, 16'h1234, 2'b11, rd, lat);
    shadow[8'h30] = merge(shadow[8'h30], 16'h1234, 2'b11);
    cpu_txn(1'b1, 8'h30, 16'hAAAA, 2'b10, rd, lat);
    shadow[8'h30] = merge(shadow[8'h30], 16'hAAAA, 2'b10);
    tests++; if (lat !== 1) begin fails++; $display("FAIL wm_wr_lat got %0d want 1", lat); end
    cpu_txn(1'b0, 8'h30, 16'h0000, 2'b11, rd, lat);
`ifdef VRAM_ARBITER_WMASK_EN
    want = 16'hAA34;
`else
    want = 16'hAAAA;
`endif
    tests++; if (rd !== want) begin fails++; $display("FAIL wm_readback got %h want %h", rd, want); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL wm_rd_lat got %0d want 2", lat); end
  endtask

  task automatic test_back_to_back();
    int acks = 0, run = 0, cyc = 0;
    int due_q[$];
    logic [15:0] val_q[$];
    logic [15:0] exp_vd = '0, exp_rd;
    logic got_ack = 1'b0;
    do_reset();
    tick();
    bus.video_en = 1'b1;
    bus.video_addr = 8'($urandom_range(0, 63));
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    bus.cpu_addr = 8'($urandom_range(0, 63));
    exp_rd = shadow[bus.cpu_addr];
    while (acks < 8 && cyc < 60) begin
      if (cyc > 0) begin
        tick();
        bus.video_addr = 8'($urandom_range(0, 63));
        if (got_ack) begin
          bus.cpu_addr = 8'($urandom_range(0, 63));
          exp_rd = shadow[bus.cpu_addr];
        end
      end
      @(negedge clk);
      got_ack = bus.cpu_ack;
      tests++; if (bus.ram_we !== 1'b0) begin fails++; $display("FAIL b2b_we cyc=%0d got %b want 0", cyc, bus.ram_we); end
      if (run % 4 == 3) begin
        tests++; if (bus.ram_addr !== bus.video_addr) begin fails++; $display("FAIL b2b_slot cyc=%0d addr=%h want %h", cyc, bus.ram_addr, bus.video_addr); end
        due_q.push_back(cyc + 2);
        val_q.push_back(shadow[bus.video_addr]);
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        exp_vd = val_q.pop_front();
      end
      tests++; if (bus.video_data !== exp_vd) begin fails++; $display("FAIL b2b_vdata cyc=%0d got %h want %h", cyc, bus.video_data, exp_vd); end
      if (got_ack) begin
        acks++;
        tests++; if (bus.cpu_rdata !== exp_rd) begin fails++; $display("FAIL b2b_rdata ack=%0d got %h want %h", acks, bus.cpu_rdata, exp_rd); end
      end
      run++;
      cyc++;
    end
    tests++; if (acks != 8) begin fails++; $display("FAIL b2b_acks got %0d want 8", acks); end
    bus.cpu_req = 1'b0;
    tick();
    bus.video_en = 1'b0;
  endtask

  task automatic test_random();
    int run = 0, t_start = 0, we_cnt = 0, lat;
    int due_q[$];
    logic [15:0] val_q[$];
    logic [15:0] exp_vd = '0, exp_rd = '0;
    logic busy = 1'b0, vs;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      bus.video_en   = ($urandom_range(0, 9) != 0);
      bus.video_addr = 8'($urandom_range(0, 15));
      if (!busy && cyc < 390 && $urandom_range(0, 1) == 1) begin
        busy = 1'b1; t_start = cyc; we_cnt = 0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'($urandom_range(0, 1));
        bus.cpu_addr  = 8'($urandom_range(0, 15));
        bus.cpu_wdata = 16'($urandom);
        bus.cpu_wmask = 2'($urandom_range(0, 3));
        exp_rd = shadow[bus.cpu_addr];
      end
      @(negedge clk);
      if (bus.video_en) begin vs = (run % 4 == 3); run++; end
      else begin vs = 1'b0; run = 0; end
      if (bus.ram_we) begin
        we_cnt++;
        tests++;
        if (!busy || !bus.cpu_we || vs || bus.ram_addr !== bus.cpu_addr || bus.ram_wdata !== bus.cpu_wdata) begin
          fails++; $display("FAIL rnd_we cyc=%0d addr=%h want %h busy=%b slot=%b", cyc, bus.ram_addr, bus.cpu_addr, busy, vs);
        end
      end
`ifdef VRAM_ARBITER_WMASK_EN
      tests++; if (bus.ram_wmask !== (bus.ram_we ? bus.cpu_wmask : 2'b00)) begin fails++; $display("FAIL rnd_wmask cyc=%0d got %b want %b", cyc, bus.ram_wmask, bus.ram_we ? bus.cpu_wmask : 2'b00); end
`else
      tests++; if (bus.ram_wmask !== 2'b11) begin fails++; $display("FAIL rnd_wmask cyc=%0d got %b want 11", cyc, bus.ram_wmask); end
`endif
      if (bus.cpu_ack) begin
        lat = cyc - t_start;
        tests++;
        if (!busy) begin
          fails++; $display("FAIL rnd_spurious_ack cyc=%0d got 1 want 0", cyc);
        end else if (bus.cpu_we) begin
          if (we_cnt != 1 || lat < 1 || lat > 2) begin fails++; $display("FAIL rnd_wr cyc=%0d we_cycles=%0d lat=%0d want 1/1..2", cyc, we_cnt, lat); end
          shadow[bus.cpu_addr] = merge(shadow[bus.cpu_addr], bus.cpu_wdata, bus.cpu_wmask);
        end else begin
          if (bus.cpu_rdata !== exp_rd || lat < 2 || lat > 3) begin fails++; $display("FAIL rnd_rd cyc=%0d data=%h want %h lat=%0d", cyc, bus.cpu_rdata, exp_rd, lat); end
        end
        busy = 1'b0; bus.cpu_req = 1'b0;
      end else if (busy && cyc - t_start > 6) begin
        tests++; fails++; $display("FAIL rnd_timeout cyc=%0d ack=0 want 1", cyc);
        busy = 1'b0; bus.cpu_req = 1'b0;
      end
      if (vs) begin
        tests++; if (bus.ram_addr !== bus.video_addr || bus.ram_we !== 1'b0) begin fails++; $display("FAIL rnd_slot cyc=%0d addr=%h want %h", cyc, bus.ram_addr, bus.video_addr); end
        due_q.push_back(cyc + 2);
        val_q.push_back(shadow[bus.video_addr]);
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        exp_vd = val_q.pop_front();
      end
      tests++; if (bus.video_data !== exp_vd) begin fails++; $display("FAIL rnd_vdata cyc=%0d got %h want %h", cyc, bus.video_data, exp_vd); end
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    int lat;
    tick();
    bus.video_en = 1'b0; bus.video_addr = 8'h33;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h12;
    @(negedge clk);
    tick();
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    tests++; if (bus.cpu_ack !== 1'b0) begin fails++; $display("FAIL rmid_ack got %b want 0", bus.cpu_ack); end
    tests++; if (bus.cpu_rdata !== 16'h0 || bus.video_data !== 16'h0) begin fails++; $display("FAIL rmid_regs rdata=%h vdata=%h want 0/0", bus.cpu_rdata, bus.video_data); end
    tests++; if (bus.ram_we !== 1'b0 || bus.ram_addr !== 8'h33) begin fails++; $display("FAIL rmid_pins we=%b addr=%h want 0/33", bus.ram_we, bus.ram_addr); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      tests++; if (bus.cpu_ack !== 1'b0) begin fails++; $display("FAIL rmid_no_ack i=%0d got %b want 0", i, bus.cpu_ack); end
    end
    cpu_txn(1'b1, 8'h40, 16'h1357, 2'b11, rd, lat);
    shadow[8'h40] = 16'h1357;
    tests++; if (lat !== 1) begin fails++; $display("FAIL rmid_idle_lat got %0d want 1", lat); end
  endtask

  initial begin
    rst = 1'b1;
    mem_init = 1'b1;
    bus.video_en = 1'b0;
    bus.video_addr = '0;
    drive_idle();
    test_reset();
    test_write_read();
    test_video();
    test_collision();
    test_wmask();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-ported 256×16 VRAM between the tile layer processor and the CPU bus. The tile fetch gets a fixed, guaranteed read slot in every 4-cycle pixel group. The CPU gets every other cycle through a req/ack handshake. The block sits between the video pipeline and the VRAM macro and owns the VRAM address, write-enable and write-data pins.

## Interface

Parameters:
- ADDR_WIDTH, 8, VRAM word address width
- DATA_WIDTH, 16, VRAM word width (must be 16; wmask is 2 bits)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- video_en  in  1  display active; enables slot counter
- video_addr  in  ADDR_WIDTH  tile word address from layer processor
- video_data  out  DATA_WIDTH  registered tile word to layer processor
- cpu_req  in  1  CPU access request; held with fields until ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU word address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_wmask  in  2  byte enables {hi, lo}
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  read data, valid while cpu_ack = 1
- ram_addr  out  ADDR_WIDTH  VRAM address
- ram_we  out  1  VRAM write enable
- ram_wmask  out  2  VRAM byte enables
- ram_wdata  out  DATA_WIDTH  VRAM write data
- ram_rdata  in  DATA_WIDTH  VRAM read data, synchronous, 1-cycle latency

## Operation

**Slot counter**
- `slot[1:0]` increments every cycle while video_en = 1.
- It is forced to 0 while video_en = 0.
- It wraps 3 → 0.

**Video slot**
- A cycle with video_en = 1 and slot = 3 is the video slot.
- During it: ram_addr = video_addr, ram_we = 0.
- `vid_pend` is set for the following cycle. In that cycle, video_data loads ram_rdata.
- With video_en = 0 there is no video slot, video_data holds its value, and every cycle is free.

**CPU FSM** (states IDLE, RD, DONE)
- IDLE:
  - If cpu_req = 1 and the cycle is not a video slot, issue the access combinationally: ram_addr = cpu_addr, ram_we = cpu_we, ram_wdata = cpu_wdata. Then go to DONE if cpu_we = 1, or to RD if cpu_we = 0.
  - If cpu_req = 1 but the cycle is the video slot, stay in IDLE with no RAM access.
- RD: cpu_rdata ← ram_rdata, then go to DONE. The RAM port is free in this cycle; the video slot may fall here.
- DONE: cpu_ack = 1, then go to IDLE. A cpu_req still high in the next IDLE cycle is treated as a new request.

**RAM pin defaults** (when no CPU issue is active)
- ram_addr = video_addr
- ram_we = 0
- ram_wdata = cpu_wdata

**Reset**
- FSM → IDLE, slot = 0, vid_pend = 0.
- cpu_ack = 0, cpu_rdata = 0, video_data = 0.
- ram_we = 0; ram_addr follows video_addr.
- Reset asserted mid-transaction aborts it with no ack. A write whose enable edge already occurred stays committed.

## Timing

- CPU write issued at cycle N: ram_we = 1 at N, cpu_ack = 1 at N+1.
- CPU read issued at cycle N: RAM data arrives at N+1, cpu_ack = 1 with cpu_rdata valid at N+2.
- Worst-case extra latency from the video slot: 1 cycle. Write ack ≤ 2 cycles after req, read ack ≤ 3 cycles after req.
- Video slot at cycle N (slot = 3): video_data is updated at the edge ending N+1 and is valid from N+2 (slot = 1) until the next update.
- Simultaneous CPU req and video slot: video always wins; the CPU request is not lost and is issued in the next cycle.
- Back-to-back CPU transactions: the minimum spacing is one ack per 2 cycles (write) or 3 cycles (read).
- video_en falling mid-group: slot goes to 0 on the next edge; a pending video_data capture still completes.

## Configuration

- `VRAM_ARBITER_WMASK_EN` defined: ram_wmask = cpu_wmask during a CPU write issue, 2'b00 otherwise.
- `VRAM_ARBITER_WMASK_EN` undefined: cpu_wmask is ignored and ram_wmask is tied to 2'b11. Full-word writes only.

## Test plan

- Reset, video_en = 0, CPU write 0xBEEF to address 0x12 → ram_we high for exactly 1 cycle with ram_addr = 0x12, ack 1 cycle later. A subsequent read of 0x12 → ack 2 cycles after issue with cpu_rdata = 0xBEEF.
- video_en = 1, RAM preloaded word 0x20 = 0x8005, video_addr = 0x20 held → video_data = 0x8005 two cycles after each slot = 3 cycle.
- CPU read of 0x05 raised exactly in a slot = 3 cycle → that cycle's ram_addr = video_addr, issue occurs in the next cycle, ack 3 cycles after req, video_data uncorrupted.
- With `VRAM_ARBITER_WMASK_EN`: write 0xAAAA with mask 2'b10 over stored 0x1234 → readback 0xAA34. Without the macro: readback 0xAAAA.
- CPU holds cpu_req high continuously across 8 back-to-back reads while video_en = 1 → every ack carries the correct data, no ram_we = 1 ever occurs, and no video slot is skipped.
- rst pulsed during the RD state → cpu_ack never rises for that transaction, FSM returns to IDLE, and all registered outputs read 0.
